// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one-outstanding imem requests and
// hands Instr/PC to decode. Optional misaligned-target trap: FETCH_MISALIGN_TRAP_EN.
module fetch_unit #(
    parameter int unsigned    XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic [XLEN-1:0] Instr,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PCPlus4,
    output logic            instr_valid,
    input  logic            instr_ready,
    input  logic [1:0]      PCSrc,
    input  logic [XLEN-1:0] PCTarget,
    input  logic [XLEN-1:0] ALUResult,
    output logic [XLEN-1:0] instr_count,
    output logic            fetch_fault
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
`ifdef FETCH_MISALIGN_TRAP_EN
        , FAULT
`endif
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] count_q, count_d;
    logic            req_valid_q, req_valid_d;
    logic            instr_valid_q, instr_valid_d;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] next_pc;

    assign pc_plus4 = pc_q + XLEN'(4);

    always_comb begin
        next_pc = pc_plus4;
        case (PCSrc)
            2'b01:   next_pc = PCTarget;
            2'b10:   next_pc = ALUResult & ~XLEN'(1);
            default: next_pc = pc_plus4;
        endcase
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    logic fault_q, fault_d;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        count_d = count_q;
`ifdef FETCH_MISALIGN_TRAP_EN
        fault_d = fault_q;
`endif
        case (state_q)
            IDLE: state_d = REQ;
            REQ:  if (imem_req_ready) state_d = WAIT;
            WAIT: begin
                if (imem_rsp_valid) begin
                    instr_d = imem_rsp_data;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (instr_ready) begin
                    count_d = count_q + XLEN'(1);
`ifdef FETCH_MISALIGN_TRAP_EN
                    // Trap keeps the raw target in PC so the handler can see it.
                    if (next_pc[1]) begin
                        pc_d    = next_pc;
                        fault_d = 1'b1;
                        state_d = FAULT;
                    end else begin
                        pc_d    = next_pc & ~XLEN'(3);
                        state_d = REQ;
                    end
`else
                    pc_d    = next_pc & ~XLEN'(3);
                    state_d = REQ;
`endif
                end
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            FAULT: state_d = FAULT;
`endif
            default: state_d = IDLE;
        endcase
        req_valid_d   = (state_d == REQ);
        instr_valid_d = (state_d == HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            count_q       <= '0;
            req_valid_q   <= 1'b0;
            instr_valid_q <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            fault_q       <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            count_q       <= count_d;
            req_valid_q   <= req_valid_d;
            instr_valid_q <= instr_valid_d;
`ifdef FETCH_MISALIGN_TRAP_EN
            fault_q       <= fault_d;
`endif
        end
    end

    assign imem_req_valid = req_valid_q;
    assign imem_addr      = pc_q;
    assign Instr          = instr_q;
    assign PC             = pc_q;
    assign PCPlus4        = pc_plus4;
    assign instr_valid    = instr_valid_q;
    assign instr_count    = count_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign fetch_fault    = fault_q;
`else
    assign fetch_fault    = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed handshakes push expected fetch
// addresses and decode-side values; two monitors pop and compare.
`timescale 1ns/1ps
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] Instr, PC, PCPlus4, instr_count;
    logic        instr_valid, instr_ready;
    logic [1:0]  PCSrc;
    logic [31:0] PCTarget, ALUResult;
    logic        fetch_fault;

    always #5 clk = ~clk;

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .Instr(Instr), .PC(PC),
        .PCPlus4(PCPlus4), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .PCSrc(PCSrc), .PCTarget(PCTarget), .ALUResult(ALUResult),
        .instr_count(instr_count), .fetch_fault(fetch_fault)
    );

    int checks = 0;
    int errors = 0;
    bit mon_done = 1'b0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] cnt;
    } exp_t;

    exp_t        exp_hs_q[$];
    logic [31:0] exp_addr_q[$];
    exp_t        mon_e;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h0050_0093 ^ a;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory model: response mem_delay cycles after the cycle following acceptance.
    int          mem_delay;
    logic        stale_v;
    logic        rsp_v, pend;
    int          cnt;
    logic [31:0] rsp_d;

    always @(posedge clk) begin
        if (rst) begin
            rsp_v <= 1'b0;
            pend  <= 1'b0;
            cnt   <= 0;
        end else begin
            rsp_v <= 1'b0;
            if (pend) begin
                if (cnt == 0) begin
                    rsp_v <= 1'b1;
                    pend  <= 1'b0;
                end else begin
                    cnt <= cnt - 1;
                end
            end
            if (imem_req_valid && imem_req_ready) begin
                rsp_d <= mem_word(imem_addr);
                if (mem_delay == 0) rsp_v <= 1'b1;
                else begin
                    pend <= 1'b1;
                    cnt  <= mem_delay - 1;
                end
            end
        end
    end

    assign imem_rsp_valid = rsp_v | stale_v;
    assign imem_rsp_data  = stale_v ? 32'hDEAD_BEEF : rsp_d;

    // Request-side monitor.
    logic rq_stall_prev = 1'b0;
    always begin
        @(negedge clk); #1;
        if (rst || mon_done) begin
            rq_stall_prev = 1'b0;
        end else begin
            if (rq_stall_prev)
                chk("req_valid_held", 32'(imem_req_valid), 32'd1);
            if (imem_req_valid) begin
                if (exp_addr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_req: addr %h, none expected", imem_addr);
                end else begin
                    chk("imem_addr", imem_addr, exp_addr_q[0]);
                    if (imem_req_ready) void'(exp_addr_q.pop_front());
                end
            end
            rq_stall_prev = imem_req_valid && !imem_req_ready;
        end
    end

    // Decode-side monitor.
    always begin
        @(negedge clk); #1;
        if (!rst && !mon_done && instr_valid) begin
            if (exp_hs_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_instr: PC %h, none expected", PC);
            end else begin
                mon_e = exp_hs_q[0];
                chk("PC", PC, mon_e.pc);
                chk("Instr", Instr, mon_e.instr);
                chk("PCPlus4", PCPlus4, mon_e.pc + 32'd4);
                chk("instr_count", instr_count, mon_e.cnt);
                chk("no_req_in_hold", 32'(imem_req_valid), 32'd0);
                if (instr_ready) void'(exp_hs_q.pop_front());
            end
        end
    end

    task automatic hs(input logic [31:0] pc, input logic [31:0] c, input logic [1:0] src,
                      input logic [31:0] tgt, input logic [31:0] alu, input logic [31:0] nxt,
                      input bit push_nxt, input int stall, input int req_stall);
        int n = 0;
        exp_hs_q.push_back('{pc, mem_word(pc), c});
        if (push_nxt) exp_addr_q.push_back(nxt);
        while (!instr_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("instr_valid_wait", 32'(instr_valid), 32'd1);
        repeat (stall) @(negedge clk);
        PCSrc       = src;
        PCTarget    = tgt;
        ALUResult   = alu;
        instr_ready = 1'b1;
        if (req_stall > 0) imem_req_ready = 1'b0;
        @(negedge clk);
        instr_ready = 1'b0;
        PCSrc       = 2'b01;
        PCTarget    = 32'hBAD0_0001;
        ALUResult   = 32'hBAD0_0003;
        if (req_stall > 0) begin
            repeat (req_stall) @(negedge clk);
            imem_req_ready = 1'b1;
        end
    endtask

    task automatic reset_checks();
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_instr_count", instr_count, 32'd0);
        chk("rst_PC", PC, 32'd0);
        chk("rst_PCPlus4", PCPlus4, 32'd4);
        chk("rst_Instr", Instr, 32'd0);
        chk("rst_fetch_fault", 32'(fetch_fault), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d checks", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; imem_req_ready = 1'b1; instr_ready = 1'b0;
        PCSrc = 2'b00; PCTarget = '0; ALUResult = '0;
        mem_delay = 0; stale_v = 1'b0;
        repeat (3) @(negedge clk);
        reset_checks();
        exp_addr_q.push_back(32'h0);
        rst = 1'b0;

        hs(32'h0000_0000, 0, 2'b00, 32'h0, 32'h0, 32'h0000_0004, 1, 0, 0);
        hs(32'h0000_0004, 1, 2'b00, 32'h0, 32'h0, 32'h0000_0008, 1, 0, 0);
        hs(32'h0000_0008, 2, 2'b00, 32'h0, 32'h0, 32'h0000_000C, 1, 0, 0);
        hs(32'h0000_000C, 3, 2'b01, 32'h40, 32'h0, 32'h0000_0040, 1, 0, 0);
        hs(32'h0000_0040, 4, 2'b10, 32'h0, 32'h81, 32'h0000_0080, 1, 0, 0);
        hs(32'h0000_0080, 5, 2'b11, 32'h200, 32'h300, 32'h0000_0084, 1, 0, 0);
        hs(32'h0000_0084, 6, 2'b00, 32'h0, 32'h0, 32'h0000_0088, 1, 5, 4);
        hs(32'h0000_0088, 7, 2'b01, 32'hFFFF_FFFC, 32'h0, 32'hFFFF_FFFC, 1, 0, 0);
        hs(32'hFFFF_FFFC, 8, 2'b00, 32'h0, 32'h0, 32'h0000_0000, 1, 0, 0);
        hs(32'h0000_0000, 9, 2'b10, 32'h0, 32'h101, 32'h0000_0100, 1, 0, 0);
        mem_delay = 3;
        hs(32'h0000_0100, 10, 2'b00, 32'h0, 32'h0, 32'h0000_0104, 1, 0, 0);

        // 0x104 is accepted on the next edge; reset while its response is pending.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        reset_checks();
        rst = 1'b0; stale_v = 1'b1; imem_req_ready = 1'b0; mem_delay = 0;
        exp_addr_q.push_back(32'h0);
        repeat (2) @(negedge clk);
        stale_v = 1'b0; imem_req_ready = 1'b1;

`ifdef FETCH_MISALIGN_TRAP_EN
        hs(32'h0000_0000, 0, 2'b01, 32'h42, 32'h0, 32'h0, 0, 0, 0);
        repeat (2) @(negedge clk);
        chk("fault_flag", 32'(fetch_fault), 32'd1);
        chk("fault_PC", PC, 32'h42);
        chk("fault_count", instr_count, 32'd1);
        chk("fault_instr_valid", 32'(instr_valid), 32'd0);
        repeat (10) @(negedge clk);
        chk("fault_sticky", 32'(fetch_fault), 32'd1);
`else
        hs(32'h0000_0000, 0, 2'b01, 32'h42, 32'h0, 32'h0000_0040, 1, 0, 0);
        hs(32'h0000_0040, 1, 2'b00, 32'h0, 32'h0, 32'h0000_0044, 1, 0, 0);
        n = 0;
        while (exp_addr_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("fault_flag_off", 32'(fetch_fault), 32'd0);
`endif
        mon_done = 1'b1;
        chk("addr_queue_drained", 32'(exp_addr_q.size()), 32'd0);
        chk("instr_queue_drained", 32'(exp_hs_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
